// File: rtl/svm_update_ctrl.sv
// Per-period command scheduler for the svm PWM core: 1-deep shadow register,
// start/stop sequencing, latched fault shutdown and underrun/drop accounting.
module svm_update_ctrl #(
    parameter int                 D_WIDTH    = 16,
    parameter logic [D_WIDTH-1:0] MIN_PERIOD = D_WIDTH'(64),
    parameter int                 CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 enable,
    input  logic                 fault,
    input  logic                 fault_clr,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [D_WIDTH-1:0]   cmd_vA,
    input  logic [D_WIDTH-1:0]   cmd_vB,
    input  logic [D_WIDTH-1:0]   cmd_vC,
    input  logic [D_WIDTH-1:0]   cmd_period,
    output logic                 svm_valid,
    input  logic                 svm_ready,
    input  logic                 svm_halt,
    output logic [D_WIDTH-1:0]   svm_vA,
    output logic [D_WIDTH-1:0]   svm_vB,
    output logic [D_WIDTH-1:0]   svm_vC,
    output logic [D_WIDTH-1:0]   svm_period,
    output logic                 pwm_en,
    output logic                 running,
    output logic                 fault_latched,
    output logic [CNT_WIDTH-1:0] underrun_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [2:0]           state_dbg
);

    // Handshakes: a transfer happens on a clock edge where valid && ready.
    // svm_valid stays high with stable data until svm_ready takes it; it is
    // only withdrawn by fault or reset.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t state, state_next;

    logic                 halt_d;
    logic                 period_end;
    logic                 shadow_full;
    logic [D_WIDTH-1:0]   sh_va, sh_vb, sh_vc, sh_period;
    logic                 svm_valid_q;
    logic                 pwm_en_q;
    logic                 zero_sent;
    logic [CNT_WIDTH-1:0] underrun_q;
    logic [CNT_WIDTH-1:0] drop_q;
    logic [D_WIDTH-1:0]   cap_period;
    logic                 cmd_xfer;
    logic                 svm_xfer;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cap_period   = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
    assign cmd_xfer     = cmd_valid & cmd_ready;
    assign svm_xfer     = svm_valid & svm_ready;
    assign underrun_cnt = underrun_q;
    assign drop_cnt     = drop_q;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (fault) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE:  if (enable && shadow_full) state_next = ST_PRIME;
                // A stop request during priming still lets the first command land.
                ST_PRIME: if (svm_xfer) state_next = enable ? ST_RUN : ST_STOP;
                ST_RUN:   if (!enable) state_next = ST_STOP;
                ST_STOP:  if (svm_xfer && zero_sent) state_next = ST_IDLE;
                ST_FAULT: if (fault_clr) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // fault gates the outward strobes combinationally so no handshake or gate
    // drive survives the cycle in which it rises.
    always_comb begin
        cmd_ready     = 1'b0;
        svm_valid     = svm_valid_q & ~fault;
        pwm_en        = pwm_en_q & ~fault;
        running       = (state == ST_RUN);
        fault_latched = (state == ST_FAULT);
        case (state)
            ST_IDLE: cmd_ready = ~shadow_full;
            ST_RUN:  cmd_ready = ~shadow_full & ~svm_valid_q;
            default: cmd_ready = 1'b0;
        endcase
        if (fault) cmd_ready = 1'b0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            halt_d      <= 1'b0;
            period_end  <= 1'b0;
            shadow_full <= 1'b0;
            sh_va       <= '0;
            sh_vb       <= '0;
            sh_vc       <= '0;
            sh_period   <= MIN_PERIOD;
            svm_valid_q <= 1'b0;
            pwm_en_q    <= 1'b0;
            zero_sent   <= 1'b0;
            underrun_q  <= '0;
            drop_q      <= '0;
            svm_vA      <= '0;
            svm_vB      <= '0;
            svm_vC      <= '0;
            svm_period  <= MIN_PERIOD;
        end else begin
            halt_d     <= svm_halt;
            period_end <= svm_halt & ~halt_d;

            if (cmd_xfer) begin
                shadow_full <= 1'b1;
                sh_va       <= cmd_vA;
                sh_vb       <= cmd_vB;
                sh_vc       <= cmd_vC;
                sh_period   <= cap_period;
            end

            if (svm_xfer) svm_valid_q <= 1'b0;

            if (fault) begin
                svm_valid_q <= 1'b0;
                pwm_en_q    <= 1'b0;
                zero_sent   <= 1'b0;
                svm_vA      <= '0;
                svm_vB      <= '0;
                svm_vC      <= '0;
                if (shadow_full) begin
                    shadow_full <= 1'b0;
                    drop_q      <= sat_inc(drop_q);
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (state_next == ST_PRIME) begin
                            svm_vA      <= sh_va;
                            svm_vB      <= sh_vb;
                            svm_vC      <= sh_vc;
                            svm_period  <= sh_period;
                            svm_valid_q <= 1'b1;
                        end
                    end
                    ST_PRIME: begin
                        if (svm_xfer) begin
                            shadow_full <= 1'b0;
                            pwm_en_q    <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (period_end && enable) begin
                            if (svm_valid_q) begin
                                // svm has not taken the previous period's command yet.
                                underrun_q <= sat_inc(underrun_q);
                            end else begin
                                svm_valid_q <= 1'b1;
                                if (shadow_full) begin
                                    svm_vA      <= sh_va;
                                    svm_vB      <= sh_vb;
                                    svm_vC      <= sh_vc;
                                    svm_period  <= sh_period;
                                    shadow_full <= 1'b0;
                                end else begin
                                    underrun_q <= sat_inc(underrun_q);
                                end
                            end
                        end
                    end
                    ST_STOP: begin
                        if (period_end && !svm_valid_q && !zero_sent) begin
                            svm_vA      <= '0;
                            svm_vB      <= '0;
                            svm_vC      <= '0;
                            svm_valid_q <= 1'b1;
                            zero_sent   <= 1'b1;
                        end
                        if (svm_xfer && zero_sent) begin
                            pwm_en_q  <= 1'b0;
                            zero_sent <= 1'b0;
                            if (shadow_full) begin
                                shadow_full <= 1'b0;
                                drop_q      <= sat_inc(drop_q);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
